axi_line_master: RTL and testbench
==================================

# axi_line_master

AXI4 master that moves whole cache lines between a cache controller and an AXI4 memory slave such as the on-chip data RAM. It issues one fixed-length 32-bit INCR burst per client request: a read burst for a line fill, or a write burst for a writeback. Read data streams to the client, and write data is pulled from the client's line buffer by word index. It is the initiator end of the AXI4 subset the data RAM serves: single ID, INCR bursts, 32-bit beats.

## Interface
Parameters:
- LINE_WORDS, 8: 32-bit words per line; power of two, 2..256. OFF = log2(LINE_WORDS*4) and IW = log2(LINE_WORDS).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid / req_ready  in / out  1  request handshake.
- req_write  in  1  1 = writeback, 0 = fill.
- req_addr  in  32  byte address; bits [OFF-1:0] are ignored.
- wr_word_idx  out  IW  index of the word the client must present on wr_word.
- wr_word  in  32  line word at wr_word_idx, driven combinationally by the client.
- rd_word_valid  out  1  fill word strobe.
- rd_word_idx  out  IW  fill word index.
- rd_word  out  32  fill word data.
- done  out  1  one-cycle completion pulse.
- err  out  1  error status, valid only while done is high.
- AXI AW channel: axi_awid out 1, axi_awaddr out 32, axi_awlen out 8, axi_awsize out 3, axi_awburst out 2, axi_awvalid out 1, axi_awready in 1.
- AXI W channel: axi_wdata out 32, axi_wstrb out 4, axi_wlast out 1, axi_wvalid out 1, axi_wready in 1.
- AXI B channel: axi_bid in 1, axi_bresp in 2, axi_bvalid in 1, axi_bready out 1.
- AXI AR channel: axi_arid out 1, axi_araddr out 32, axi_arlen out 8, axi_arsize out 3, axi_arburst out 2, axi_arvalid out 1, axi_arready in 1.
- AXI R channel: axi_rid in 1, axi_rdata in 32, axi_rresp in 2, axi_rlast in 1, axi_rvalid in 1, axi_rready out 1.

## Operation
- States: IDLE, AR, R, AW, W, B.
- IDLE: req_ready = 1. When req_valid is high, latch {req_addr[31:OFF], OFF zeros} and clear the beat counter and the error flag. Next state is AW if req_write = 1, otherwise AR.
- AR: axi_arvalid = 1 with the latched address. Move to R on axi_arready.
- R: axi_rready = 1. On each beat (axi_rvalid && axi_rready):
  - rd_word_valid = 1, rd_word = axi_rdata, rd_word_idx = counter; all three are combinational, same cycle as the beat.
  - Increment the counter.
  - Set the error flag if axi_rresp != 0.
  - On the axi_rlast beat, set the error flag if counter != LINE_WORDS-1, then go to IDLE with done.
  - Beats arriving after counter wraps without axi_rlast set the error flag and are not forwarded.
- AW: axi_awvalid = 1. Move to W on axi_awready. No W beat is issued before AW completes.
- W: axi_wvalid = 1, axi_wdata = wr_word, wr_word_idx = counter, axi_wlast = (counter == LINE_WORDS-1). On axi_wready, increment the counter; after the last beat, go to B.
- B: axi_bready = 1. On axi_bvalid, set the error flag if axi_bresp != 0, then go to IDLE with done.
- Constant outputs:
  - axi_awid and axi_arid = 0.
  - axi_awlen and axi_arlen = LINE_WORDS-1.
  - axi_awsize and axi_arsize = 3'b010.
  - axi_awburst and axi_arburst = 2'b01.
  - axi_wstrb = 4'hF.
- axi_bid and axi_rid are ignored.

## Timing
- Reset values: state IDLE, req_ready 1, every valid/ready output 0, axi_wlast 0, done 0, err 0, counter 0, address 0.
- Request accepted at edge N → AXI address valid during cycle N+1.
- AXI rules:
  - A valid output, once asserted, stays high until its handshake.
  - Address, data and wlast stay stable while valid is high and ready is low.
  - The master never waits on slave ready to raise its own valid.
- Final R beat or B handshake at edge M → done = 1 and req_ready = 1 during cycle M+1. err = registered error flag during that same cycle.
- A new request may be accepted in the done cycle.
- Minimum fill: 1 AR cycle + LINE_WORDS beats. Minimum writeback: 1 AW cycle + LINE_WORDS W cycles + 1 B cycle.
- The counter is IW bits and wraps naturally.
- Reset asserted mid-burst: all outputs take reset values immediately (asynchronously), and the transaction is abandoned. The system resets the slave with the same reset.

## Test plan
- Fill, LINE_WORDS=8, req_addr 0x0000_1234:
  - AR carries araddr 0x0000_1220, arlen 7, arsize 2, arburst 1.
  - Slave returns 0xA0..0xA7 → rd_word_idx 0..7 carries matching data, exactly one done, err 0.
- Writeback, req_addr 0x40, client line word i = 0x100+i:
  - AW carries awaddr 0x40, awlen 7.
  - wdata runs 0x100..0x107 with wlast only on beat 7 and wstrb F; no W beat before the AW handshake.
  - done follows the bvalid handshake.
- Backpressure: arready held low 5 cycles, then rvalid toggling every cycle → araddr stable while arvalid is high; rd_word_idx advances only on handshakes; 8 words delivered.
- wready low on alternate cycles → wdata, wlast and wr_word_idx hold during stalls; 8 beats total.
- Errors:
  - bresp = 2'b10 → done with err 1.
  - rlast on beat 5 of 8 → done after that beat with err 1.
  - rresp = 2'b11 on beat 3 → err 1 at done.
- rst low during W beat 4 → axi_wvalid and done drop in the same cycle. After release: req_ready 1, and the next fill completes correctly.

Source files
------------

// File: rtl/axi_line_master.sv
// AXI4 line master: one fixed-length INCR burst per cache-line request,
// a read burst for a fill or a write burst for a writeback. rst is active-low.
module axi_line_master #(
  parameter  int LINE_WORDS = 8,
  localparam int OFF        = $clog2(LINE_WORDS * 4),
  localparam int IW         = $clog2(LINE_WORDS)
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [31:0]   req_addr,

  output logic [IW-1:0] wr_word_idx,
  input  logic [31:0]   wr_word,

  output logic          rd_word_valid,
  output logic [IW-1:0] rd_word_idx,
  output logic [31:0]   rd_word,

  output logic          done,
  output logic          err,

  output logic          axi_awid,
  output logic [31:0]   axi_awaddr,
  output logic [7:0]    axi_awlen,
  output logic [2:0]    axi_awsize,
  output logic [1:0]    axi_awburst,
  output logic          axi_awvalid,
  input  logic          axi_awready,

  output logic [31:0]   axi_wdata,
  output logic [3:0]    axi_wstrb,
  output logic          axi_wlast,
  output logic          axi_wvalid,
  input  logic          axi_wready,

  input  logic          axi_bid,
  input  logic [1:0]    axi_bresp,
  input  logic          axi_bvalid,
  output logic          axi_bready,

  output logic          axi_arid,
  output logic [31:0]   axi_araddr,
  output logic [7:0]    axi_arlen,
  output logic [2:0]    axi_arsize,
  output logic [1:0]    axi_arburst,
  output logic          axi_arvalid,
  input  logic          axi_arready,

  input  logic          axi_rid,
  input  logic [31:0]   axi_rdata,
  input  logic [1:0]    axi_rresp,
  input  logic          axi_rlast,
  input  logic          axi_rvalid,
  output logic          axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(LINE_WORDS - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] cnt, cnt_nxt;
  logic [31:0]   addr, addr_nxt;
  logic          err_q, err_nxt;
  logic          wrap_q, wrap_nxt;
  logic          done_q, done_nxt;

  logic          unused_inputs;
  assign unused_inputs = ^{axi_bid, axi_rid, req_addr[OFF-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      addr   <= '0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      addr   <= addr_nxt;
      err_q  <= err_nxt;
      wrap_q <= wrap_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    err_nxt   = err_q;
    wrap_nxt  = wrap_q;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          addr_nxt  = {req_addr[31:OFF], {OFF{1'b0}}};
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          wrap_nxt  = 1'b0;
          state_nxt = req_write ? S_AW : S_AR;
        end
      end
      S_AR: begin
        if (axi_arready) state_nxt = S_R;
      end
      S_R: begin
        if (axi_rvalid) begin
          cnt_nxt = cnt + IW'(1);
          if (axi_rresp != 2'b00) err_nxt = 1'b1;
          // Once the counter has wrapped the slave is overrunning the line.
          if (wrap_q) err_nxt = 1'b1;
          if (cnt == LAST_IDX) wrap_nxt = 1'b1;
          if (axi_rlast) begin
            if (cnt != LAST_IDX || wrap_q) err_nxt = 1'b1;
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      S_AW: begin
        if (axi_awready) state_nxt = S_W;
      end
      S_W: begin
        if (axi_wready) begin
          cnt_nxt = cnt + IW'(1);
          if (cnt == LAST_IDX) state_nxt = S_B;
        end
      end
      S_B: begin
        if (axi_bvalid) begin
          if (axi_bresp != 2'b00) err_nxt = 1'b1;
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_ready     = (state == S_IDLE);
  assign done          = done_q;
  assign err           = done_q & err_q;

  assign axi_arvalid   = (state == S_AR);
  assign axi_araddr    = addr;
  assign axi_arid      = 1'b0;
  assign axi_arlen     = 8'(LINE_WORDS - 1);
  assign axi_arsize    = 3'b010;
  assign axi_arburst   = 2'b01;

  assign axi_rready    = (state == S_R);
  assign rd_word_valid = axi_rready & axi_rvalid & ~wrap_q;
  assign rd_word_idx   = cnt;
  assign rd_word       = axi_rdata;

  assign axi_awvalid   = (state == S_AW);
  assign axi_awaddr    = addr;
  assign axi_awid      = 1'b0;
  assign axi_awlen     = 8'(LINE_WORDS - 1);
  assign axi_awsize    = 3'b010;
  assign axi_awburst   = 2'b01;

  assign axi_wvalid    = (state == S_W);
  assign wr_word_idx   = cnt;
  assign axi_wdata     = wr_word;
  assign axi_wstrb     = 4'hF;
  assign axi_wlast     = axi_wvalid & (cnt == LAST_IDX);

  assign axi_bready    = (state == S_B);

endmodule

// File: tb/tb_axi_line_master.sv
// Bench for axi_line_master: directed fills/writebacks; a negedge monitor
// pops expected AXI/client events from queues filled by the stimulus.
module tb_axi_line_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [2:0]  wr_word_idx, rd_word_idx;
  logic [31:0] wr_word, rd_word;
  logic        rd_word_valid, done, err;
  logic        axi_awid, axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bid, axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic        axi_arid, axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rid, axi_rlast, axi_rvalid, axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;

  logic [31:0] wr_line [8];
  assign wr_word = wr_line[wr_word_idx];

  always #5 clk = ~clk;

  axi_line_master #(.LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .wr_word_idx(wr_word_idx), .wr_word(wr_word),
    .rd_word_valid(rd_word_valid), .rd_word_idx(rd_word_idx), .rd_word(rd_word),
    .done(done), .err(err),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] ar_q[$], aw_q[$], w_q[$], rd_q[$];
  logic        done_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic empty_pop(input string name);
    checks++;
    errors++;
    $display("FAIL %s unexpected event actual=present expected=none", name);
  endtask

  // Monitor: samples at negedge, i.e. exactly what the next rising edge sees.
  logic        ar_stall, aw_stall, w_stall, aw_seen;
  logic [31:0] ar_prev, aw_prev;
  logic [35:0] w_prev;
  logic [63:0] e;
  logic        e_err;

  always @(negedge clk) begin
    if (!rst) begin
      ar_stall = 1'b0; aw_stall = 1'b0; w_stall = 1'b0; aw_seen = 1'b0;
    end else begin
      if (ar_stall) begin
        chk("arvalid_hold", 64'(axi_arvalid), 64'd1);
        chk("araddr_hold", 64'(axi_araddr), 64'(ar_prev));
      end
      if (axi_arvalid && axi_arready) begin
        if (ar_q.size() == 0) empty_pop("ar_hs");
        else begin
          e = ar_q.pop_front();
          chk("ar_fields", 64'({axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst}), e);
        end
      end
      ar_stall = axi_arvalid && !axi_arready;
      ar_prev  = axi_araddr;

      if (aw_stall) begin
        chk("awvalid_hold", 64'(axi_awvalid), 64'd1);
        chk("awaddr_hold", 64'(axi_awaddr), 64'(aw_prev));
      end
      if (axi_awvalid && axi_awready) begin
        aw_seen = 1'b1;
        if (aw_q.size() == 0) empty_pop("aw_hs");
        else begin
          e = aw_q.pop_front();
          chk("aw_fields", 64'({axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst}), e);
        end
      end
      aw_stall = axi_awvalid && !axi_awready;
      aw_prev  = axi_awaddr;

      if (w_stall) begin
        chk("wvalid_hold", 64'(axi_wvalid), 64'd1);
        chk("w_hold", 64'({axi_wdata, axi_wlast, wr_word_idx}), 64'(w_prev));
      end
      if (axi_wvalid) chk("w_after_aw", 64'(aw_seen), 64'd1);
      if (axi_wvalid && axi_wready) begin
        if (w_q.size() == 0) empty_pop("w_hs");
        else begin
          e = w_q.pop_front();
          chk("w_beat", 64'({axi_wdata, axi_wlast, axi_wstrb}), e);
        end
      end
      w_stall = axi_wvalid && !axi_wready;
      w_prev  = {axi_wdata, axi_wlast, wr_word_idx};

      if (rd_word_valid) begin
        if (rd_q.size() == 0) empty_pop("rd_word");
        else begin
          e = rd_q.pop_front();
          chk("rd_word", 64'({8'(rd_word_idx), rd_word}), e);
        end
      end

      if (done) begin
        aw_seen = 1'b0;
        if (done_q.size() == 0) empty_pop("done");
        else begin
          e_err = done_q.pop_front();
          chk("done_err", 64'(err), 64'(e_err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string name);
    chk(name, 64'({req_ready, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready,
                   axi_wlast, done, err, rd_word_valid}), 64'(10'b10_0000_0000));
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr);
    chk("req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    chk(name, 64'(done), 64'd1);
    for (int i = 0; i < 20 && !done; i++) tick();
  endtask

  task automatic do_fill(input logic [31:0] addr, input logic [31:0] exp_araddr,
                         input logic [31:0] base, input int ar_delay, input bit toggle,
                         input int nbeats, input int resp_beat, input logic [1:0] resp_val,
                         input bit exp_err);
    ar_q.push_back(64'({1'b0, exp_araddr, 8'd7, 3'd2, 2'd1}));
    for (int b = 0; b < nbeats; b++) rd_q.push_back(64'({8'(b), base + 32'(b)}));
    done_q.push_back(exp_err);
    issue(1'b0, addr);
    for (int i = 0; i < ar_delay; i++) tick();
    axi_arready = 1'b1;
    tick();
    axi_arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (toggle) begin
        axi_rvalid = 1'b0;
        tick();
      end
      axi_rvalid = 1'b1;
      axi_rdata  = base + 32'(b);
      axi_rresp  = (b == resp_beat) ? resp_val : 2'b00;
      axi_rlast  = (b == nbeats - 1);
      tick();
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
    wait_done("fill_done_latency");
  endtask

  task automatic wb_addr_and_data(input logic [31:0] addr, input logic [31:0] exp_awaddr,
                                  input logic [31:0] base, input bit alt, input int nbeats);
    int n;
    for (int i = 0; i < 8; i++) wr_line[i] = base + 32'(i);
    aw_q.push_back(64'({1'b0, exp_awaddr, 8'd7, 3'd2, 2'd1}));
    for (int b = 0; b < nbeats; b++) w_q.push_back(64'({base + 32'(b), b == 7, 4'hF}));
    issue(1'b1, addr);
    tick();
    axi_awready = 1'b1;
    tick();
    axi_awready = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < nbeats; c++) begin
      axi_wready = alt ? (c % 2 == 1) : 1'b1;
      if (axi_wvalid && axi_wready) n++;
      tick();
    end
    axi_wready = 1'b0;
    chk("w_beat_count", 64'(n), 64'(nbeats));
  endtask

  task automatic do_wb(input logic [31:0] addr, input logic [31:0] exp_awaddr,
                       input logic [31:0] base, input bit alt, input logic [1:0] bresp,
                       input bit exp_err);
    bit hs;
    done_q.push_back(exp_err);
    wb_addr_and_data(addr, exp_awaddr, base, alt, 8);
    axi_bvalid = 1'b1;
    axi_bresp  = bresp;
    hs = 1'b0;
    for (int i = 0; i < 10 && !hs; i++) begin
      hs = axi_bready;
      tick();
    end
    axi_bvalid = 1'b0; axi_bresp = 2'b00;
    chk("b_handshake", 64'(hs), 64'd1);
    wait_done("wb_done_latency");
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    axi_awready = 1'b0; axi_wready = 1'b0;
    axi_bid = 1'b0; axi_bresp = 2'b00; axi_bvalid = 1'b0;
    axi_arready = 1'b0;
    axi_rid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; axi_rlast = 1'b0; axi_rvalid = 1'b0;
    for (int i = 0; i < 8; i++) wr_line[i] = '0;
    tick();
    tick();
    check_reset("reset_outputs");
    rst = 1'b1;
    tick();

    do_fill(32'h0000_1234, 32'h0000_1220, 32'hA0, 0, 1'b0, 8, -1, 2'b00, 1'b0);
    do_wb(32'h0000_0040, 32'h0000_0040, 32'h100, 1'b0, 2'b00, 1'b0);
    do_fill(32'h0000_2010, 32'h0000_2000, 32'hB0, 5, 1'b1, 8, -1, 2'b00, 1'b0);
    do_wb(32'h0000_009C, 32'h0000_0080, 32'h200, 1'b1, 2'b00, 1'b0);
    do_wb(32'h0000_00C0, 32'h0000_00C0, 32'h300, 1'b0, 2'b10, 1'b1);
    do_fill(32'h0000_0300, 32'h0000_0300, 32'h50, 0, 1'b0, 6, -1, 2'b00, 1'b1);
    do_fill(32'h0000_0400, 32'h0000_0400, 32'h60, 1, 1'b0, 8, 3, 2'b11, 1'b1);

    // Reset while W beat 4 is on the bus: transaction is abandoned, no done.
    wb_addr_and_data(32'h0000_0500, 32'h0000_0500, 32'h400, 1'b0, 4);
    chk("w_beat4_present", 64'({axi_wvalid, 8'(wr_word_idx)}), 64'({1'b1, 8'd4}));
    axi_wready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_reset("mid_burst_reset");
    axi_wready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("req_ready_after_reset", 64'(req_ready), 64'd1);
    do_fill(32'h0000_0FFC, 32'h0000_0FE0, 32'hC0, 0, 1'b0, 8, -1, 2'b00, 1'b0);

    tick();
    tick();
    chk("ar_q_left", 64'(ar_q.size()), 64'd0);
    chk("aw_q_left", 64'(aw_q.size()), 64'd0);
    chk("w_q_left", 64'(w_q.size()), 64'd0);
    chk("rd_q_left", 64'(rd_q.size()), 64'd0);
    chk("done_q_left", 64'(done_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
